// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM request controller.
// Contents: address/data widths, controller state enum, response record.
package sram_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   typedef enum logic {ST_INIT, ST_RUN} sram_ctrl_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
   } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO holding returned read records.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (flushes)
//   push       write push_data this cycle
//   push_data  record to store
//   pop        discard the head record this cycle (never issued when empty)
//   pop_data   head record, stable until popped
//   count      number of stored records
// Push and pop may coincide, including when full; the count is then unchanged.
module sram_rsp_fifo
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  sram_rsp_t        push_data,
   input  logic             pop,
   output sram_rsp_t        pop_data,
   output logic [CNT_W-1:0] count
);

   sram_rsp_t        mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign pop_data = mem[rptr];

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for an 8-bit synchronous SRAM port.
// Accepts read/write requests (valid/ready), drives registered wr/rd/addr/wdata,
// tracks reads through a READ_LAT-deep pipe and returns them in order through a
// response FIFO (valid/ready). Credits keep reads in flight plus queued
// responses within RSP_DEPTH, so read data is never dropped under backpressure.
// With CLEAR_ON_RST=1 the whole SRAM is zero-filled after reset before RUN.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_wr/req_addr/req_wdata   request channel
//   rsp_valid/rsp_ready/rsp_addr/rsp_rdata          read response channel
//   wr/rd/addr/wdata (out), rdata (in)              SRAM port
//   init_done                        high once in RUN
//   rd_cnt/wr_cnt                    saturating accepted-read/write counts
// Build option: define SRAM_REQ_CTRL_STATS_EN to implement rd_cnt/wr_cnt;
// otherwise both are tied to zero and no counter flops exist.
module sram_req_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned READ_LAT     = 1,
   parameter int unsigned RSP_DEPTH    = 4,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              wr,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              init_done,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

   sram_ctrl_state_e    state_q, state_d;
   logic [ADDR_W-1:0]   sweep_q;
   logic [READ_LAT-1:0] pipe_v;
   logic [READ_LAT-1:0] pipe_keep;
   logic [ADDR_W-1:0]   pipe_a [READ_LAT];
   logic                acc, acc_rd, acc_wr;
   logic                push, pop, ready_d;
   logic [CNT_W-1:0]    fifo_cnt;
   sram_rsp_t           fifo_in, fifo_out;
   int unsigned         inflight_n, fifo_cnt_n;

   // req_ready is registered, so it is computed from next-cycle occupancy:
   // reads issued/in the pipe after this edge plus FIFO entries after this edge.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && sweep_q == '1) state_d = ST_RUN;
      acc    = req_valid && req_ready;
      acc_rd = acc && !req_wr;
      acc_wr = acc && req_wr;
      push   = pipe_v[READ_LAT-1];
      pop    = rsp_valid && rsp_ready;
      pipe_keep = pipe_v;
      pipe_keep[READ_LAT-1] = 1'b0;
      inflight_n = 32'(acc_rd) + 32'(rd) + 32'($countones(pipe_keep));
      fifo_cnt_n = 32'(fifo_cnt) + 32'(push) - 32'(pop);
      ready_d    = (state_d == ST_RUN) && (inflight_n + fifo_cnt_n < RSP_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR_ON_RST ? ST_INIT : ST_RUN;
         sweep_q   <= '0;
         wr        <= 1'b0;
         rd        <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
         pipe_v    <= '0;
         for (int unsigned i = 0; i < READ_LAT; i++) pipe_a[i] <= '0;
      end else begin
         state_q   <= state_d;
         req_ready <= ready_d;
         init_done <= (state_d == ST_RUN);
         pipe_v[0] <= rd;
         pipe_a[0] <= addr;
         for (int unsigned i = 1; i < READ_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
         if (state_q == ST_INIT) begin
            wr      <= 1'b1;
            rd      <= 1'b0;
            addr    <= sweep_q;
            wdata   <= '0;
            sweep_q <= sweep_q + 1'b1;
         end else begin
            wr <= acc_wr;
            rd <= acc_rd;
            if (acc) begin
               addr  <= req_addr;
               wdata <= req_wdata;
            end
         end
      end
   end

   assign fifo_in = {pipe_a[READ_LAT-1], rdata};

   sram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (fifo_in),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_cnt)
   );

   assign rsp_valid = (fifo_cnt != '0);
   assign rsp_addr  = fifo_out.addr;
   assign rsp_rdata = fifo_out.rdata;

`ifdef SRAM_REQ_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (acc_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
         if (acc_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      end
   end
`else
   assign rd_cnt = '0;
   assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl with a behavioural SRAM and a
// reference model (memory image + expected-response queue).
module tb_sram_req_ctrl;

   localparam int unsigned READ_LAT     = 1;
   localparam int unsigned RSP_DEPTH    = 4;
   localparam bit          CLEAR_ON_RST = 1'b1;
`ifdef SRAM_REQ_CTRL_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
   logic [7:0]  req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [7:0]  rsp_addr, rsp_rdata;
   logic        wr, rd;
   logic [7:0]  addr, wdata, rdata;
   logic        init_done;
   logic [15:0] rd_cnt, wr_cnt;

   sram_req_ctrl #(
      .READ_LAT     (READ_LAT),
      .RSP_DEPTH    (RSP_DEPTH),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready), .req_wr (req_wr),
      .req_addr (req_addr), .req_wdata (req_wdata),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
      .rsp_addr (rsp_addr), .rsp_rdata (rsp_rdata),
      .wr (wr), .rd (rd), .addr (addr), .wdata (wdata), .rdata (rdata),
      .init_done (init_done), .rd_cnt (rd_cnt), .wr_cnt (wr_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural synchronous SRAM: contents seeded non-zero, read data appears
   // READ_LAT edges after the edge that samples rd.
   logic [7:0] sram [256];
   logic [7:0] rd_pipe [READ_LAT];
   logic       seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 256; i++) sram[i] <= 8'($urandom_range(1, 255));
         seeded <= 1'b1;
      end else if (wr) begin
         sram[addr] <= wdata;
      end
      rd_pipe[0] <= sram[addr];
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rdata = rd_pipe[READ_LAT-1];

   // Reference model state
   logic [7:0]  ref_mem [256];
   logic [15:0] exp_q [$];
   int unsigned n_rd = 0, n_wr = 0;
   int unsigned checks = 0, failures = 0;
   bit          run_chk = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int unsigned n);
      return STATS_EN ? ((n > 65535) ? 32'd65535 : n) : 32'd0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      n_rd = 0;
      n_wr = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
   endtask

   // One clock: update model from handshakes seen before the edge, then
   // check registered outputs at the following negedge.
   task automatic tick(output bit acc_o);
      bit          acc, pop, hold, w;
      logic [7:0]  a, d, pa, pd, ha, hd;
      logic [15:0] e;
      acc = req_valid && req_ready;
      w = req_wr; a = req_addr; d = req_wdata;
      pop = rsp_valid && rsp_ready;
      hold = rsp_valid && !rsp_ready;
      pa = addr; pd = wdata; ha = rsp_addr; hd = rsp_rdata;
      if (pop) begin
         check("rsp_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_addr", rsp_addr, e[15:8]);
            check("rsp_rdata", rsp_rdata, e[7:0]);
         end
      end
      if (acc) begin
         if (w) begin
            ref_mem[a] = d;
            n_wr++;
         end else begin
            exp_q.push_back({a, ref_mem[a]});
            n_rd++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (run_chk) begin
         check("wr_strobe", wr, acc && w);
         check("rd_strobe", rd, acc && !w);
         check("issue_addr", addr, acc ? a : pa);
         check("issue_wdata", wdata, acc ? d : pd);
         if (hold) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_addr", rsp_addr, ha);
            check("rsp_hold_rdata", rsp_rdata, hd);
         end
      end
      acc_o = acc;
   endtask

   task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d);
      bit got = 1'b0;
      req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
      for (int c = 0; c < 50 && !got; c++) tick(got);
      req_valid = 1'b0;
      check("issue_accepted", got, 1);
   endtask

   task automatic drain();
      bit g;
      int unsigned c = 0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || rsp_valid) && c < 60) begin
         tick(g);
         c++;
      end
      check("drain_queue", 32'(exp_q.size()), 0);
      check("drain_rsp_valid", rsp_valid, 0);
   endtask

   task automatic reset_checks();
      check("rst_wr", wr, 0);
      check("rst_rd", rd, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_init_done", init_done, 0);
      check("rst_rd_cnt", rd_cnt, 0);
      check("rst_wr_cnt", wr_cnt, 0);
   endtask

   // Called right after rst is released at a negedge.
   task automatic wait_init();
      int unsigned idx = 0;
      bit done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (wr) begin
            check("sweep_addr", addr, idx);
            check("sweep_wdata", wdata, 0);
            idx++;
         end
         if (init_done) done = 1'b1;
      end
      check("sweep_len", idx, CLEAR_ON_RST ? 256 : 0);
      check("init_done", init_done, 1);
   endtask

   task automatic check_counters();
      check("rd_cnt", rd_cnt, exp_cnt(n_rd));
      check("wr_cnt", wr_cnt, exp_cnt(n_wr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          got;
      int unsigned k, idx, c;
      logic [7:0]  a6 [6];

      // Reset and clear sweep
      model_reset();
      repeat (3) @(negedge clk);
      reset_checks();
      rst = 1'b0;
      wait_init();
      run_chk = 1'b1;
      issue(1'b0, 8'h7F, 8'h00);
      drain();

      // Write then read, with response latency
      rsp_ready = 1'b0;
      issue(1'b1, 8'h10, 8'hA5);
      issue(1'b0, 8'h10, 8'h00);
      k = 0;
      while (!rsp_valid && k < 20) begin
         tick(got);
         k++;
      end
      check("rsp_latency", k, READ_LAT + 1);
      drain();

      // Backpressure: credits cap accepted reads at RSP_DEPTH
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) a6[i] = 8'($urandom);
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         if (idx < 6) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = a6[idx];
         end else req_valid = 1'b0;
         tick(got);
         if (got) idx++;
      end
      check("bp_accepted", idx, RSP_DEPTH);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (idx < 6) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = a6[idx];
         end else req_valid = 1'b0;
         tick(got);
         if (got) idx++;
      end
      check("bp_all_accepted", idx, 6);
      drain();

      // Alternating write/read, one access per cycle
      idx = 0;
      c = 0;
      while (idx < 16 && c < 40) begin
         req_valid = 1'b1;
         req_wr    = (idx % 2 == 0);
         req_addr  = 8'(idx / 2 + 1);
         req_wdata = 8'(idx / 2 + 1) ^ 8'hFF;
         tick(got);
         if (got) idx++;
         c++;
      end
      req_valid = 1'b0;
      check("alt_cycles", c, 16);
      drain();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_wr    = 1'($urandom_range(0, 1));
         req_addr  = 8'($urandom_range(0, 15));
         req_wdata = 8'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick(got);
      end
      drain();
      check_counters();

      // Reset with reads in flight
      rsp_ready = 1'b0;
      issue(1'b0, 8'h20, 8'h00);
      issue(1'b0, 8'h21, 8'h00);
      issue(1'b0, 8'h22, 8'h00);
      rst = 1'b1;
      run_chk = 1'b0;
      @(negedge clk);
      reset_checks();
      model_reset();
      rst = 1'b0;
      wait_init();
      run_chk = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(got);
         check("no_stale_rsp", rsp_valid, 0);
      end

      // Statistics counters
      issue(1'b1, 8'h30, 8'h11);
      issue(1'b0, 8'h30, 8'h00);
      issue(1'b1, 8'h31, 8'h22);
      issue(1'b1, 8'h32, 8'h33);
      issue(1'b0, 8'h32, 8'h00);
      drain();
      check_counters();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
